// File: rtl/rf_multiport.sv
// Multi-port register file: one write port, two registered read ports, per-entry valid bits
// and a sequenced soft-clear engine. Define RF_BYPASS_EN for write-first read-during-write.
module rf_multiport #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wAddr,
    input  logic [DATA_W-1:0] wData,
    input  logic [ADDR_W-1:0] rAddr0,
    output logic [DATA_W-1:0] rData0,
    output logic              rValid0,
    input  logic [ADDR_W-1:0] rAddr1,
    output logic [DATA_W-1:0] rData1,
    output logic              rValid1,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e              r_state;
    state_e              w_state_d;
    logic [ADDR_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]   w_cnt_d;
    logic                r_done;
    logic                w_done_d;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DEPTH-1:0]    r_valid;
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;
    logic                r_rvalid0;
    logic                r_rvalid1;

    logic                w_wr_acc;
    logic                w_clr_act;
    logic                w_last;
    logic [DATA_W-1:0]   w_rdata0;
    logic [DATA_W-1:0]   w_rdata1;
    logic                w_rvalid0;
    logic                w_rvalid1;

    assign w_wr_acc  = we && (r_state == StIdle);
    assign w_clr_act = (r_state == StClear);
    // All-ones counter is exactly DEPTH-1; terminal detection never relies on wrap-around.
    assign w_last    = (r_cnt == {ADDR_W{1'b1}});

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_done_d  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (clr_req) begin
                    w_state_d = StClear;
                    w_cnt_d   = '0;
                end
            end
            StClear: begin
                w_cnt_d = r_cnt + ADDR_W'(1);
                if (w_last) begin
                    w_state_d = StIdle;
                    w_done_d  = 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_rdata0  = r_mem[rAddr0];
        w_rvalid0 = r_valid[rAddr0];
        w_rdata1  = r_mem[rAddr1];
        w_rvalid1 = r_valid[rAddr1];
`ifdef RF_BYPASS_EN
        if (w_wr_acc && (rAddr0 == wAddr)) begin
            w_rdata0  = wData;
            w_rvalid0 = 1'b1;
        end
        if (w_wr_acc && (rAddr1 == wAddr)) begin
            w_rdata1  = wData;
            w_rvalid1 = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_done  <= w_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_valid   <= '0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            // Writes and clears are mutually exclusive since writes only land in IDLE.
            if (w_wr_acc) begin
                r_mem[wAddr]   <= wData;
                r_valid[wAddr] <= 1'b1;
            end else if (w_clr_act) begin
                r_mem[r_cnt]   <= '0;
                r_valid[r_cnt] <= 1'b0;
            end
            r_rdata0  <= w_rdata0;
            r_rvalid0 <= w_rvalid0;
            r_rdata1  <= w_rdata1;
            r_rvalid1 <= w_rvalid1;
        end
    end

    assign rData0   = r_rdata0;
    assign rValid0  = r_rvalid0;
    assign rData1   = r_rdata1;
    assign rValid1  = r_rvalid1;
    assign clr_busy = (r_state == StClear);
    assign clr_done = r_done;

endmodule

// File: tb/tb_rf_multiport.sv
// Directed self-checking bench for rf_multiport: default 8x32 instance plus a 16x16 instance.
module tb_rf_multiport;

    logic        clk = 1'b0;
    logic        reset_n;

    // 8 x 32 instance
    logic        we, clr_req;
    logic [2:0]  wAddr, rAddr0, rAddr1;
    logic [31:0] wData, rData0, rData1;
    logic        rValid0, rValid1, clr_busy, clr_done;

    // 16 x 16 instance
    logic        b_we, b_clr_req;
    logic [3:0]  b_wAddr, b_rAddr0, b_rAddr1;
    logic [15:0] b_wData, b_rData0, b_rData1;
    logic        b_rValid0, b_rValid1, b_clr_busy, b_clr_done;

    int n_vec = 0;
    int n_err = 0;
    int busy_cnt, done_cnt;

    always #5 clk = ~clk;

    rf_multiport #(.DATA_W(32), .ADDR_W(3)) u_dut (
        .clk(clk), .reset_n(reset_n), .we(we), .wAddr(wAddr), .wData(wData),
        .rAddr0(rAddr0), .rData0(rData0), .rValid0(rValid0),
        .rAddr1(rAddr1), .rData1(rData1), .rValid1(rValid1),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
    );

    rf_multiport #(.DATA_W(16), .ADDR_W(4)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .we(b_we), .wAddr(b_wAddr), .wData(b_wData),
        .rAddr0(b_rAddr0), .rData0(b_rData0), .rValid0(b_rValid0),
        .rAddr1(b_rAddr1), .rData1(b_rData1), .rValid1(b_rValid1),
        .clr_req(b_clr_req), .clr_busy(b_clr_busy), .clr_done(b_clr_done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        we = 1'b1; wAddr = a; wData = d;
        tick();
        we = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int a = 0; a < 8; a++) begin
            rAddr0 = 3'(a); rAddr1 = 3'(7 - a);
            tick();
            chk({tag, "_d0"}, rData0, 0);
            chk({tag, "_v0"}, rValid0, 0);
            chk({tag, "_d1"}, rData1, 0);
            chk({tag, "_v1"}, rValid1, 0);
        end
    endtask

    initial begin
        reset_n = 1'b0; we = 1'b0; clr_req = 1'b0; wAddr = '0; wData = '0;
        rAddr0 = '0; rAddr1 = '0;
        b_we = 1'b0; b_clr_req = 1'b0; b_wAddr = '0; b_wData = '0;
        b_rAddr0 = '0; b_rAddr1 = '0;
        tick(); tick();
        reset_n = 1'b1;

        // Reset state
        chk("rst_busy", clr_busy, 0);
        chk("rst_done", clr_done, 0);
        check_all_zero("rst");

        // Basic write then dual read
        wr(3'd3, 32'hDEADBEEF);
        wr(3'd5, 32'h12345678);
        rAddr0 = 3'd3; rAddr1 = 3'd5;
        tick();
        chk("rd_d0", rData0, 32'hDEADBEEF);
        chk("rd_v0", rValid0, 1);
        chk("rd_d1", rData1, 32'h12345678);
        chk("rd_v1", rValid1, 1);

        // Read-during-write on the same address
        wr(3'd2, 32'h11);
        rAddr0 = 3'd2; rAddr1 = 3'd2;
        we = 1'b1; wAddr = 3'd2; wData = 32'hA5A5A5A5;
        tick();
        we = 1'b0;
`ifdef RF_BYPASS_EN
        chk("rdw_d0", rData0, 32'hA5A5A5A5);
`else
        chk("rdw_d0", rData0, 32'h11);
`endif
        chk("rdw_v0", rValid0, 1);
        tick();
        chk("rdw_next_d0", rData0, 32'hA5A5A5A5);

        // Fill all entries, then soft clear
        for (int a = 0; a < 8; a++) wr(3'(a), 32'h100 + 32'(a));
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        chk("clr_busy_start", clr_busy, 1);
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (clr_busy) busy_cnt++;
            if (clr_done) done_cnt++;
            if (i == 8) chk("clr_done_at8", clr_done, 1);
            if (i == 2) begin
                rAddr0 = 3'd7; rAddr1 = 3'd0;
            end
            if (i == 3) begin
                chk("clr_mid_d0", rData0, 32'h107);
                chk("clr_mid_v0", rValid0, 1);
                chk("clr_mid_d1", rData1, 0);
                chk("clr_mid_v1", rValid1, 0);
            end
            // Entry 4 is already cleared here; this write must be dropped.
            we = (i == 5);
            wAddr = 3'd4; wData = 32'hFFFF_0004;
            tick();
        end
        we = 1'b0;
        chk("clr_busy_cycles", busy_cnt, 8);
        chk("clr_done_pulses", done_cnt, 1);
        check_all_zero("post_clr");

        // Simultaneous write and clear request in IDLE
        clr_req = 1'b1; we = 1'b1; wAddr = 3'd1; wData = 32'hCAFE0001;
        tick();
        clr_req = 1'b0; we = 1'b0;
        rAddr0 = 3'd1;
        tick();
        chk("wrclr_d0", rData0, 32'hCAFE0001);
        chk("wrclr_v0", rValid0, 1);
        for (int i = 0; i < 10; i++) tick();
        chk("wrclr_idle", clr_busy, 0);

        // Reset in the middle of a clear
        wr(3'd6, 32'h66);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick(); tick();
        chk("midrst_busy_pre", clr_busy, 1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("midrst_busy", clr_busy, 0);
        chk("midrst_done", clr_done, 0);
        tick();
        chk("midrst_done2", clr_done, 0);
        chk("midrst_busy2", clr_busy, 0);
        check_all_zero("midrst");

        // 16 x 16 instance: full-depth clear, entry 15 cleared last
        b_we = 1'b1; b_wAddr = 4'd15; b_wData = 16'hBEEF;
        tick();
        b_wAddr = 4'd14; b_wData = 16'h1414;
        tick();
        b_we = 1'b0;
        b_rAddr0 = 4'd15; b_rAddr1 = 4'd14;
        b_clr_req = 1'b1;
        tick();
        b_clr_req = 1'b0;
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            if (b_clr_busy) busy_cnt++;
            if (b_clr_done) done_cnt++;
            if (i == 15) begin
                chk("b_s15_d0", b_rData0, 16'hBEEF);
                chk("b_s15_d1", b_rData1, 16'h1414);
            end
            if (i == 16) begin
                chk("b_s16_d0", b_rData0, 16'hBEEF);
                chk("b_s16_v0", b_rValid0, 1);
                chk("b_s16_d1", b_rData1, 0);
                chk("b_s16_done", b_clr_done, 1);
            end
            if (i == 17) begin
                chk("b_s17_d0", b_rData0, 0);
                chk("b_s17_v0", b_rValid0, 0);
            end
            tick();
        end
        chk("b_busy_cycles", busy_cnt, 16);
        chk("b_done_pulses", done_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rf_multiport.md
# rf_multiport

Parametrised register file: one synchronous write port, two registered read ports, a valid flag per entry, and a sequenced soft-clear engine. It replaces the fixed 8×32 single-read register file in the datapath, so operand fetch can read two sources per cycle and software can clear the array without asserting global reset.

## Interface
Parameters:
- DATA_W, 32, width of each entry and of wData/rData0/rData1
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries, so every address is legal

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset_n  input  1  synchronous, active-low reset
- we  input  1  write enable
- wAddr  input  ADDR_W  write address
- wData  input  DATA_W  write data
- rAddr0  input  ADDR_W  read port 0 address
- rData0  output  DATA_W  read port 0 data, registered
- rValid0  output  1  entry read on port 0 has been written since the last clear, registered
- rAddr1  input  ADDR_W  read port 1 address
- rData1  output  DATA_W  read port 1 data, registered
- rValid1  output  1  same as rValid0, for port 1
- clr_req  input  1  start a soft clear (level, sampled only in IDLE)
- clr_busy  output  1  soft clear in progress
- clr_done  output  1  one-cycle pulse when a soft clear completes

## Operation
- Storage: DEPTH×DATA_W data array plus a DEPTH-bit valid vector.
- Reset (reset_n=0 at an edge):
  - all entries, all valid bits, rData0/1, rValid0/1, clr_busy, clr_done and the clear counter go to 0;
  - FSM goes to IDLE;
  - this overrides every other input, including a clear already in progress.
- Write: when we=1 and FSM=IDLE, the next edge sets entry[wAddr]=wData and valid[wAddr]=1. Writes while FSM=CLEAR are dropped.
- Read: each port registers {valid[rAddrN], entry[rAddrN]} every cycle. The two ports are independent and may use the same address.
- Soft-clear FSM:
  - IDLE: clr_req=1 → CLEAR, counter=0, clr_busy=1.
  - CLEAR: each cycle sets entry[counter]=0 and valid[counter]=0, then increments counter.
  - When counter=DEPTH-1 is cleared: → IDLE, clr_busy=0, clr_done=1 for exactly one cycle.
  - clr_req is ignored while in CLEAR. If clr_req is still high on return to IDLE, a new clear starts on the following edge.
- During CLEAR, reads return the current array contents: already-cleared entries read as 0 with valid 0; entries not yet cleared keep their old value.
- Arithmetic: the counter is ADDR_W bits wide. Terminal detection compares against DEPTH-1, never against wrap-around.

## Timing
- Read latency is 1 cycle: rAddrN sampled at edge N gives rDataN/rValidN valid after edge N, held until the next edge.
- Write latency is 1 cycle: the value is in the array after the edge. A read of the same address in the same cycle follows the rule under Configuration.
- Soft clear takes DEPTH cycles. clr_busy is high for exactly DEPTH cycles. clr_done pulses on the cycle after clr_busy falls, i.e. the edge that clears the last entry sets clr_done.
- A simultaneous clr_req=1 and we=1 in IDLE: the write is performed, then the clear starts. Clearing entry 0 happens one edge later.
- A write and a clear of the same entry in the same cycle cannot occur, because writes are dropped in CLEAR.

## Configuration
- RF_BYPASS_EN defined: a read port whose address equals wAddr while a write is accepted (we=1, IDLE) captures wData and valid=1 at that edge (write-first).
- RF_BYPASS_EN undefined: that read captures the pre-write entry and valid (read-first). The new value is visible one cycle later.
- The bypass never applies in CLEAR, because writes are dropped there.

## Test plan
- Reset then read all addresses on both ports → rData=0, rValid=0. clr_busy=0, clr_done=0.
- Write 0xDEADBEEF to 3, then 0x12345678 to 5; next cycle rAddr0=3, rAddr1=5 → rData0=0xDEADBEEF, rData1=0x12345678, both rValid=1.
- Same-cycle we=1, wAddr=2, wData=0xA5A5A5A5 with rAddr0=2 (entry 2 previously 0x11):
  - with RF_BYPASS_EN: rData0=0xA5A5A5A5 next cycle;
  - without: rData0=0x11, then 0xA5A5A5A5 a cycle later.
- Fill all 8 entries, pulse clr_req → clr_busy high 8 cycles, clr_done single pulse. A write to 4 during CLEAR is dropped. Afterwards all reads return 0, rValid=0.
- Start a soft clear, assert reset_n=0 at cycle 3 of CLEAR → next cycle FSM IDLE, clr_busy=0, no clr_done, all entries 0.
- DATA_W=16, ADDR_W=4: write 0xBEEF to 15, clear takes 16 cycles, counter does not wrap early, and entry 15 is cleared last.
